// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO on the load/store data bus.
// Optional build macro UART_TX_IRQ_EN adds a registered irq output (idle and drained).
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        wr,
    input  logic [3:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        tx
`ifdef UART_TX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + PTR_W'(1);
    endfunction

    logic             sel;
    logic [1:0]       reg_idx;
    logic             wr_en;
    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             ovf_set;
    logic             ovf_clr;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [3:0]       count_nib;

    logic [15:0]      bauddiv;
    logic             tx_en;
    logic             irq_en;
    logic             overflow;
    logic             irq_flag;

    logic [1:0]       state;
    logic [15:0]      div_q;
    logic [15:0]      baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             tx_q;
    logic             bit_end;
    logic             busy;

    logic             unused_bits;

    assign sel      = cs && (addr[31:4] == BASE_ADDR[31:4]);
    assign reg_idx  = addr[3:2];
    assign wr_en    = sel && wr;
    assign push_req = wr_en && (reg_idx == REG_TXDATA) && mask[0];
    assign ovf_clr  = wr_en && (reg_idx == REG_STATUS) && mask[0] && data_wr[3];

    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign count_nib  = 4'(fifo_count);

    assign bit_end = (baud_cnt == 16'd0);
    assign busy    = (state != ST_IDLE);

    // A new frame is loaded from IDLE, or straight out of a finished stop bit.
    assign pop = tx_en && !fifo_empty &&
                 ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign push_ok = push_req && (!fifo_full || pop);
    assign ovf_set = push_req && fifo_full && !pop;

    assign unused_bits = &{1'b0, data_wr[31:16], mask[3:2], addr[1:0]};

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[tail] <= data_wr[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) begin
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bauddiv  <= DEFAULT_DIV;
            tx_en    <= 1'b1;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_en && (reg_idx == REG_BAUDDIV)) begin
                if (mask[0]) begin
                    bauddiv[7:0] <= data_wr[7:0];
                end
                if (mask[1]) begin
                    bauddiv[15:8] <= data_wr[15:8];
                end
            end
            if (wr_en && (reg_idx == REG_CTRL) && mask[0]) begin
                tx_en  <= data_wr[0];
                irq_en <= data_wr[1];
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            shift <= fifo_mem[head];
        end else if ((state == ST_DATA) && bit_end) begin
            shift <= {1'b0, shift[7:1]};
        end
    end

    // tx is registered alongside the state so the line never glitches on decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            div_q    <= DEFAULT_DIV;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            tx_q     <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        state    <= ST_START;
                        div_q    <= bauddiv;
                        baud_cnt <= bauddiv;
                        bit_idx  <= 3'd0;
                        tx_q     <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state    <= ST_DATA;
                        baud_cnt <= div_q;
                        tx_q     <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= div_q;
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            tx_q  <= 1'b1;
                        end else begin
                            tx_q  <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            state    <= ST_START;
                            div_q    <= bauddiv;
                            baud_cnt <= bauddiv;
                            bit_idx  <= 3'd0;
                            tx_q     <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            tx_q  <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

    assign tx = tx_q;

`ifdef UART_TX_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_en && fifo_empty && (state == ST_IDLE);
        end
    end
    assign irq_flag = irq;
`else
    assign irq_flag = 1'b0;
`endif

    always_comb begin
        data_rd = 32'h0;
        if (sel && !wr) begin
            case (reg_idx)
                REG_STATUS:  data_rd = {23'h0, irq_flag, count_nib, overflow,
                                        fifo_empty, fifo_full, busy};
                REG_BAUDDIV: data_rd = {16'h0, bauddiv};
                REG_CTRL:    data_rd = {30'h0, irq_en, tx_en};
                default:     data_rd = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: queued bytes are checked cycle-by-cycle on tx.
module tb_uart_tx_mmio;

    localparam logic [31:0] A_TX = 32'h0000_1000;
    localparam logic [31:0] A_ST = 32'h0000_1004;
    localparam logic [31:0] A_BD = 32'h0000_1008;
    localparam logic [31:0] A_CT = 32'h0000_100C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0;
    logic        wr = 1'b0;
    logic [3:0]  mask = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] data_wr = 32'h0;
    logic [31:0] data_rd;
    logic        tx;
`ifdef UART_TX_IRQ_EN
    logic        irq;
`endif

    uart_tx_mmio dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .wr      (wr),
        .mask    (mask),
        .addr    (addr),
        .data_wr (data_wr),
        .data_rd (data_rd),
`ifdef UART_TX_IRQ_EN
        .irq     (irq),
`endif
        .tx      (tx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] div;
        logic [7:0]  data;
    } frame_t;

    frame_t sb[$];
    int     vectors = 0;
    int     miscompares = 0;
    int     cyc = 0;
    bit     mon_busy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_frame(input logic [15:0] d, input logic [7:0] b);
        frame_t f;
        f.div  = d;
        f.data = b;
        sb.push_back(f);
    endtask

    task automatic bus_write(input logic c, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] m);
        @(negedge clk);
        cs = c; wr = 1'b1; addr = a; data_wr = d; mask = m;
        @(posedge clk);
        #1;
        cs = 1'b0; wr = 1'b0; mask = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        cs = 1'b1; wr = 1'b0; addr = a;
        #1;
        d = data_rd;
        cs = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] s;
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            bus_read(A_ST, s);
            if (sb.size() == 0 && !mon_busy && !s[0]) begin
                ok = 1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s_drain: pending=%0d busy=%b, required all frames sent", tag, sb.size(), s[0]);
        end
    endtask

    // Serial monitor: every cycle of each frame is compared against the queued byte.
    initial begin : monitor
        frame_t f;
        logic   e;
        bit     aborted;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                mon_busy = 1;
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_frame at cycle %0d: tx=0 with no byte queued", cyc);
                    for (int i = 0; i < 20000 && tx !== 1'b1; i++) @(negedge clk);
                end else begin
                    f = sb.pop_front();
                    aborted = 0;
                    for (int b = 0; b < 10 && !aborted; b++) begin
                        for (int c = 0; c <= int'(f.div) && !aborted; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (rst) begin
                                aborted = 1;
                            end else begin
                                if (b == 0)      e = 1'b0;
                                else if (b == 9) e = 1'b1;
                                else             e = f.data[b-1];
                                vectors++;
                                if (tx !== e) begin
                                    miscompares++;
                                    $display("FAIL frame_bit byte=%h bit=%0d sub=%0d: tx=%b required=%b",
                                             f.data, b, c, tx, e);
                                end
                            end
                        end
                    end
                end
                mon_busy = 0;
            end
        end
    end

    task automatic test_reset;
        logic [31:0] d;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus_read(A_ST, d);
        vectors++;
        if (d !== 32'h4) begin miscompares++; $display("FAIL reset_status: got %h required %h", d, 32'h4); end
        bus_read(A_BD, d);
        vectors++;
        if (d !== 32'd867) begin miscompares++; $display("FAIL reset_bauddiv: got %0d required 867", d); end
        bus_read(A_CT, d);
        vectors++;
        if (d !== 32'h1) begin miscompares++; $display("FAIL reset_ctrl: got %h required 1", d); end
        vectors++;
        if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b required 1", tx); end
`ifdef UART_TX_IRQ_EN
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b required 0", irq); end
`endif
    endtask

    task automatic test_single_frame;
        logic [31:0] s;
        int n, rel;
        bit done;
        bus_write(1'b1, A_BD, 32'd3, 4'b0011);
        expect_frame(16'd3, 8'h55);
        bus_write(1'b1, A_TX, 32'h55, 4'b0001);
        n = cyc;
        vectors++;
        if (tx !== 1'b1) begin miscompares++; $display("FAIL single_tx_at_N: got %b required 1", tx); end
        @(posedge clk);
        #1;
        vectors++;
        if (tx !== 1'b0) begin miscompares++; $display("FAIL single_tx_fall_N1: got %b required 0", tx); end
        done = 0;
        rel = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            bus_read(A_ST, s);
            if (!s[0]) begin
                rel = cyc - n;
                done = 1;
                break;
            end
        end
        vectors++;
        if (!done || rel != 41) begin
            miscompares++;
            $display("FAIL single_busy_drop: at N+%0d required N+41", rel);
        end
        wait_done("single");
    endtask

    task automatic test_back_to_back;
        logic [31:0] s;
        int n, rel, first_idle;
        bus_write(1'b1, A_BD, 32'd0, 4'b0011);
        expect_frame(16'd0, 8'hA5);
        expect_frame(16'd0, 8'h3C);
        bus_write(1'b1, A_TX, 32'hA5, 4'b0001);
        bus_write(1'b1, A_TX, 32'h3C, 4'b0001);
        n = cyc - 1;
        first_idle = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            bus_read(A_ST, s);
            rel = cyc - n;
            if (rel == 10) begin
                vectors++;
                if (s[7:4] !== 4'd1) begin miscompares++; $display("FAIL b2b_count_before_pop: got %0d required 1", s[7:4]); end
            end
            if (rel == 11) begin
                vectors++;
                if (s[7:4] !== 4'd0) begin miscompares++; $display("FAIL b2b_count_after_pop: got %0d required 0", s[7:4]); end
            end
            if (!s[0] && first_idle < 0) first_idle = rel;
        end
        vectors++;
        if (first_idle != 21) begin
            miscompares++;
            $display("FAIL b2b_busy_drop: at N+%0d required N+21", first_idle);
        end
        wait_done("b2b");
    endtask

    task automatic test_overflow;
        logic [31:0] s;
        bus_write(1'b1, A_BD, 32'd1, 4'b0011);
        bus_write(1'b1, A_CT, 32'd0, 4'b0001);
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) expect_frame(16'd1, 8'(i * 8'h11));
            bus_write(1'b1, A_TX, 32'(i * 8'h11), 4'b0001);
        end
        bus_read(A_ST, s);
        vectors++;
        if (s !== 32'h4A) begin miscompares++; $display("FAIL ovf_status: got %h required %h", s, 32'h4A); end
        bus_write(1'b1, A_ST, 32'h8, 4'b0001);
        bus_read(A_ST, s);
        vectors++;
        if (s !== 32'h42) begin miscompares++; $display("FAIL ovf_clear: got %h required %h", s, 32'h42); end
        // First pop and this push land on the same edge with the FIFO full.
        bus_write(1'b1, A_CT, 32'd1, 4'b0001);
        expect_frame(16'd1, 8'h77);
        bus_write(1'b1, A_TX, 32'h77, 4'b0001);
        bus_read(A_ST, s);
        vectors++;
        if (s !== 32'h43) begin miscompares++; $display("FAIL full_push_pop: got %h required %h", s, 32'h43); end
        wait_done("ovf");
        bus_read(A_ST, s);
        vectors++;
        if (s !== 32'h4) begin miscompares++; $display("FAIL ovf_final_status: got %h required %h", s, 32'h4); end
    endtask

    task automatic test_mid_frame_div;
        logic [31:0] s;
        bus_write(1'b1, A_BD, 32'd3, 4'b0011);
        expect_frame(16'd3, 8'hC3);
        expect_frame(16'd7, 8'h0F);
        bus_write(1'b1, A_TX, 32'hC3, 4'b0001);
        bus_write(1'b1, A_TX, 32'h0F, 4'b0001);
        repeat (8) @(posedge clk);
        bus_write(1'b1, A_BD, 32'd7, 4'b0001);
        bus_read(A_BD, s);
        vectors++;
        if (s !== 32'd7) begin miscompares++; $display("FAIL div_readback: got %0d required 7", s); end
        wait_done("middiv");
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] s;
        bus_write(1'b1, A_BD, 32'd3, 4'b0011);
        expect_frame(16'd3, 8'h96);
        expect_frame(16'd3, 8'h69);
        bus_write(1'b1, A_TX, 32'h96, 4'b0001);
        bus_write(1'b1, A_TX, 32'h69, 4'b0001);
        repeat (14) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (tx !== 1'b1) begin miscompares++; $display("FAIL rstmid_tx: got %b required 1", tx); end
        rst = 1'b0;
        sb.delete();
        bus_read(A_ST, s);
        vectors++;
        if (s !== 32'h4) begin miscompares++; $display("FAIL rstmid_status: got %h required %h", s, 32'h4); end
        bus_read(A_BD, s);
        vectors++;
        if (s !== 32'd867) begin miscompares++; $display("FAIL rstmid_bauddiv: got %0d required 867", s); end
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (tx !== 1'b1) begin miscompares++; $display("FAIL rstmid_tx_idle: got %b required 1", tx); end
    endtask

    task automatic test_bus_isolation;
        logic [31:0] s;
        bus_write(1'b1, A_BD, 32'd0, 4'b0011);
        bus_write(1'b1, A_CT, 32'd0, 4'b0001);
        bus_write(1'b0, A_TX, 32'hAB, 4'b0001);
        bus_read(A_ST, s);
        vectors++;
        if (s[7:4] !== 4'd0) begin miscompares++; $display("FAIL iso_cs0_count: got %0d required 0", s[7:4]); end
        bus_write(1'b1, 32'h0000_2000, 32'hAB, 4'b0001);
        bus_write(1'b1, 32'h0000_1010, 32'hAB, 4'b0001);
        bus_read(A_ST, s);
        vectors++;
        if (s[7:4] !== 4'd0) begin miscompares++; $display("FAIL iso_window_count: got %0d required 0", s[7:4]); end
        bus_write(1'b1, A_TX, 32'hAB, 4'b1110);
        bus_read(A_ST, s);
        vectors++;
        if (s !== 32'h4) begin miscompares++; $display("FAIL iso_mask_status: got %h required %h", s, 32'h4); end
        cs = 1'b0; wr = 1'b0; addr = A_BD;
        #1;
        vectors++;
        if (data_rd !== 32'h0) begin miscompares++; $display("FAIL iso_rd_cs0: got %h required 0", data_rd); end
        cs = 1'b1; addr = 32'h0000_2008;
        #1;
        vectors++;
        if (data_rd !== 32'h0) begin miscompares++; $display("FAIL iso_rd_window: got %h required 0", data_rd); end
        wr = 1'b1; mask = 4'h0; addr = A_CT;
        #1;
        vectors++;
        if (data_rd !== 32'h0) begin miscompares++; $display("FAIL iso_rd_during_wr: got %h required 0", data_rd); end
        cs = 1'b0; wr = 1'b0;
        bus_read(A_TX, s);
        vectors++;
        if (s !== 32'h0) begin miscompares++; $display("FAIL iso_txdata_read: got %h required 0", s); end
        bus_write(1'b1, A_TX, 32'h5A, 4'b0001);
        bus_read(A_ST, s);
        vectors++;
        if (s[7:4] !== 4'd1) begin miscompares++; $display("FAIL iso_valid_push: got %0d required 1", s[7:4]); end
        expect_frame(16'd0, 8'h5A);
        bus_write(1'b1, A_CT, 32'd1, 4'b0001);
        wait_done("iso");
    endtask

`ifdef UART_TX_IRQ_EN
    task automatic test_irq;
        logic [31:0] s;
        int n, rel;
        bus_write(1'b1, A_BD, 32'd0, 4'b0011);
        bus_write(1'b1, A_CT, 32'd3, 4'b0001);
        @(posedge clk);
        #1;
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_idle: got %b required 1", irq); end
        expect_frame(16'd0, 8'hE1);
        bus_write(1'b1, A_TX, 32'hE1, 4'b0001);
        n = cyc;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            rel = cyc - n;
            if (rel == 11) begin
                vectors++;
                if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_early: got %b required 0", irq); end
            end
            if (rel == 12) begin
                bus_read(A_ST, s);
                vectors++;
                if (irq !== 1'b1 || s !== 32'h104) begin
                    miscompares++;
                    $display("FAIL irq_rise: irq=%b status=%h required 1 and %h", irq, s, 32'h104);
                end
            end
        end
        bus_write(1'b1, A_CT, 32'd1, 4'b0001);
        wait_done("irq");
    endtask
`endif

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_mid_frame_div();
        test_reset_mid_frame();
        test_bus_isolation();
`ifdef UART_TX_IRQ_EN
        test_irq();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
